// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for load_store_unit.
// slave: the unit itself; master: the pipeline and memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_unsigned;
  logic        mem_read_write;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_data_in, mem_access_size, mem_unsigned, mem_read_write
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr, mem_data_in, mem_access_size, mem_unsigned, mem_read_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator between the MEM stage and byte-addressable data memory.
// Define LSU_MISALIGN_EN to split misaligned half/word accesses into byte cycles.
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input logic               i_clock,
  input logic               i_reset,
  load_store_unit_if.slave  io_bus
);

`ifdef LSU_MISALIGN_EN
  typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
`endif

  localparam logic [32:0] DepthExt = 33'(MEM_DEPTH);

  state_e      r_state, w_state_next;
  logic        r_write, r_unsigned, r_error;
  logic [1:0]  r_size;
  logic [31:0] r_offset, r_wdata, r_result;

  logic        w_accept, w_range_err, w_aligned, w_error;
  logic [31:0] w_offset;
  logic [32:0] w_end;
  logic [2:0]  w_bytes;

  assign w_offset = io_bus.req_addr - BASE_ADDR;

  always_comb begin
    w_bytes = 3'd1;
    case (io_bus.req_size)
      2'b01:   w_bytes = 3'd2;
      2'b10:   w_bytes = 3'd4;
      default: w_bytes = 3'd1;
    endcase
  end

  // 33-bit end offset so a request near 4 GiB cannot wrap past the depth check
  assign w_end       = {1'b0, w_offset} + {30'b0, w_bytes};
  assign w_range_err = (io_bus.req_size == 2'b11) || (io_bus.req_addr < BASE_ADDR) ||
                       (w_end > DepthExt);
  assign w_aligned   = (io_bus.req_size == 2'b00) ||
                       ((io_bus.req_size == 2'b01) && !io_bus.req_addr[0]) ||
                       ((io_bus.req_size == 2'b10) && (io_bus.req_addr[1:0] == 2'b00));
`ifdef LSU_MISALIGN_EN
  assign w_error = w_range_err;
`else
  assign w_error = w_range_err || !w_aligned;
`endif

  assign io_bus.req_ready = (r_state == StIdle) && !i_reset;
  assign w_accept         = io_bus.req_valid && io_bus.req_ready;

`ifdef LSU_MISALIGN_EN
  logic [1:0]  r_cnt;
  logic        w_last;
  logic [31:0] w_split_result;

  assign w_last = (r_size == 2'b01) ? (r_cnt == 2'd1) : (r_cnt == 2'd3);

  always_comb begin
    w_split_result = r_result;
    w_split_result[{r_cnt, 3'b000} +: 8] = io_bus.mem_data_out[7:0];
    if (w_last && (r_size == 2'b01) && !r_unsigned) begin
      w_split_result[31:16] = {16{w_split_result[15]}};
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next                = r_state;
    io_bus.mem_addr             = '0;
    io_bus.mem_data_in          = '0;
    io_bus.mem_access_size      = 2'b00;
    io_bus.mem_unsigned         = 1'b0;
    io_bus.mem_read_write       = 1'b0;
    io_bus.resp_valid           = 1'b0;
    io_bus.resp_rdata           = '0;
    io_bus.resp_error           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_error) w_state_next = StResp;
`ifdef LSU_MISALIGN_EN
          else if (!w_aligned) w_state_next = StSplit;
`endif
          else w_state_next = StAccess;
        end
      end
      StAccess: begin
        io_bus.mem_addr        = r_offset;
        io_bus.mem_data_in     = r_wdata;
        io_bus.mem_access_size = r_size;
        io_bus.mem_unsigned    = r_unsigned;
        io_bus.mem_read_write  = r_write;
        w_state_next           = StResp;
      end
`ifdef LSU_MISALIGN_EN
      StSplit: begin
        io_bus.mem_addr        = r_offset + {30'b0, r_cnt};
        io_bus.mem_data_in     = {24'b0, r_wdata[{r_cnt, 3'b000} +: 8]};
        io_bus.mem_unsigned    = 1'b1;
        io_bus.mem_read_write  = r_write;
        if (w_last) w_state_next = StResp;
      end
`endif
      StResp: begin
        io_bus.resp_valid = 1'b1;
        io_bus.resp_rdata = r_result;
        io_bus.resp_error = r_error;
        w_state_next      = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // Quiet the memory port during reset so an in-flight store commits nothing more
    if (i_reset) begin
      io_bus.mem_addr        = '0;
      io_bus.mem_data_in     = '0;
      io_bus.mem_access_size = 2'b00;
      io_bus.mem_unsigned    = 1'b0;
      io_bus.mem_read_write  = 1'b0;
      io_bus.resp_valid      = 1'b0;
      io_bus.resp_rdata      = '0;
      io_bus.resp_error      = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_error    <= 1'b0;
      r_size     <= 2'b00;
      r_offset   <= '0;
      r_wdata    <= '0;
      r_result   <= '0;
`ifdef LSU_MISALIGN_EN
      r_cnt      <= 2'd0;
`endif
    end else begin
      if (w_accept) begin
        r_write    <= io_bus.req_write;
        r_unsigned <= io_bus.req_unsigned;
        r_size     <= io_bus.req_size;
        r_offset   <= w_offset;
        r_wdata    <= io_bus.req_wdata;
        r_error    <= w_error;
        r_result   <= '0;
`ifdef LSU_MISALIGN_EN
        r_cnt      <= 2'd0;
`endif
      end
      if ((r_state == StAccess) && !r_write) r_result <= io_bus.mem_data_out;
`ifdef LSU_MISALIGN_EN
      if (r_state == StSplit) begin
        r_cnt <= r_cnt + 2'd1;
        if (!r_write) r_result <= w_split_result;
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;
  localparam logic [31:0] Base  = 32'h0100_0000;
  localparam int unsigned Depth = 1048576;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.BASE_ADDR(Base), .MEM_DEPTH(Depth)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Memory model: combinational read with size/sign handling, write on posedge
  logic [7:0]  mem [0:1023];
  logic [9:0]  ri;
  logic [7:0]  rb0, rb1, rb2, rb3;
  always_comb begin
    ri  = bus.mem_addr[9:0];
    rb0 = mem[ri];
    rb1 = mem[ri + 10'd1];
    rb2 = mem[ri + 10'd2];
    rb3 = mem[ri + 10'd3];
    case (bus.mem_access_size)
      2'b00:   bus.mem_data_out = bus.mem_unsigned ? {24'b0, rb0} : {{24{rb0[7]}}, rb0};
      2'b01:   bus.mem_data_out = bus.mem_unsigned ? {16'b0, rb1, rb0} :
                                  {{16{rb1[7]}}, rb1, rb0};
      default: bus.mem_data_out = {rb3, rb2, rb1, rb0};
    endcase
  end

  logic        mem_quiet;
  assign mem_quiet = (bus.mem_addr == 32'b0) && (bus.mem_data_in == 32'b0) &&
                     (bus.mem_access_size == 2'b00) && !bus.mem_unsigned && !bus.mem_read_write;

  int          act_total = 0;
  int          wr_total  = 0;
  int          resp_total = 0;
  logic [1:0]  last_size;
  logic        last_rw;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  always @(posedge clk) begin
    if (!mem_quiet) begin
      act_total <= act_total + 1;
      last_size <= bus.mem_access_size;
      last_rw   <= bus.mem_read_write;
    end
    if (bus.mem_read_write) begin
      wr_addr[wr_total[2:0]] <= bus.mem_addr;
      wr_data[wr_total[2:0]] <= bus.mem_data_in;
      wr_total <= wr_total + 1;
      mem[bus.mem_addr[9:0]] <= bus.mem_data_in[7:0];
      if (bus.mem_access_size != 2'b00) mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_data_in[15:8];
      if (bus.mem_access_size == 2'b10) begin
        mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_data_in[23:16];
        mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_data_in[31:24];
      end
    end
    if (bus.resp_valid) resp_total <= resp_total + 1;
  end

  // One transaction; lat counts cycles after the accept edge, 99 on timeout
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    int g;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_size = 2'b11;
    bus.req_unsigned = ~u; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h5A5A_5A5A;
    lat = 99; rd = 32'hBAD0_BAD0; e = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; e = bus.resp_error;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    n_vec++; if (mem_quiet !== 1'b1) begin n_bad++; $display("FAIL rst_mem_quiet: got %b want 1", mem_quiet); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_aligned_word();
    logic [31:0] rd; logic e; int lat; int a0;
    do_req(1'b1, 2'b10, 1'b0, Base + 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL sw_rdata: got %h want 0", rd); end
    a0 = act_total;
    do_req(1'b0, 2'b10, 1'b0, Base + 32'h10, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw_error: got %b want 0", e); end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_vec++; if (act_total - a0 !== 1) begin n_bad++; $display("FAIL lw_mem_cycles: got %0d want 1", act_total - a0); end
    n_vec++; if ({last_size, last_rw} !== 3'b100) begin n_bad++; $display("FAIL lw_mem_kind: got size %b rw %b want 10/0", last_size, last_rw); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 2'b10, 1'b0, Base, 32'h0, rd, e, lat);
    do_req(1'b1, 2'b10, 1'b0, Base + 32'h4, 32'h0, rd, e, lat);
    do_req(1'b1, 2'b00, 1'b0, Base + 32'h3, 32'h0000_00A5, rd, e, lat);
    do_req(1'b0, 2'b00, 1'b0, Base + 32'h3, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hFFFF_FFA5) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffffa5", rd); end
    do_req(1'b0, 2'b00, 1'b1, Base + 32'h3, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000_00A5) begin n_bad++; $display("FAIL lbu_rdata: got %h want 000000a5", rd); end
    do_req(1'b0, 2'b10, 1'b0, Base, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hA500_0000) begin n_bad++; $display("FAIL sb_neighbours_lo: got %h want a5000000", rd); end
    do_req(1'b0, 2'b10, 1'b0, Base + 32'h4, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL sb_neighbours_hi: got %h want 0", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic e; int lat; int w0;
    w0 = wr_total;
    do_req(1'b1, 2'b10, 1'b0, Base + 32'h1, 32'h1122_3344, rd, e, lat);
`ifdef LSU_MISALIGN_EN
    n_vec++; if (lat !== 5 || e !== 1'b0) begin n_bad++; $display("FAIL split_sw_resp: got lat %0d err %b want 5/0", lat, e); end
    n_vec++; if (wr_total - w0 !== 4) begin n_bad++; $display("FAIL split_sw_writes: got %0d want 4", wr_total - w0); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (wr_addr[(w0 + k) % 8] !== 32'(k + 1) ||
          wr_data[(w0 + k) % 8] !== {24'b0, 8'h44 - 8'(k * 8'h11)}) begin
        n_bad++;
        $display("FAIL split_sw_byte%0d: got addr %h data %h want addr %h data %h", k,
                 wr_addr[(w0 + k) % 8], wr_data[(w0 + k) % 8], k + 1, 8'h44 - 8'(k * 8'h11));
      end
    end
    do_req(1'b0, 2'b10, 1'b0, Base + 32'h1, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h1122_3344 || lat !== 5) begin n_bad++; $display("FAIL split_lw: got %h lat %0d want 11223344 lat 5", rd, lat); end
    do_req(1'b1, 2'b00, 1'b0, Base + 32'h5, 32'h34, rd, e, lat);
    do_req(1'b1, 2'b00, 1'b0, Base + 32'h6, 32'h80, rd, e, lat);
    do_req(1'b0, 2'b01, 1'b0, Base + 32'h5, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hFFFF_8034 || lat !== 3) begin n_bad++; $display("FAIL split_lh: got %h lat %0d want ffff8034 lat 3", rd, lat); end
    do_req(1'b0, 2'b01, 1'b1, Base + 32'h5, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000_8034) begin n_bad++; $display("FAIL split_lhu: got %h want 00008034", rd); end
`else
    n_vec++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL misalign_sw_err: got lat %0d err %b rd %h want 1/1/0", lat, e, rd); end
    n_vec++; if (wr_total - w0 !== 0) begin n_bad++; $display("FAIL misalign_sw_writes: got %0d want 0", wr_total - w0); end
    do_req(1'b0, 2'b10, 1'b0, Base, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hA500_0000) begin n_bad++; $display("FAIL misalign_mem_kept: got %h want a5000000", rd); end
    do_req(1'b0, 2'b01, 1'b0, Base + 32'h5, 32'h0, rd, e, lat);
    n_vec++; if (lat !== 1 || e !== 1'b1) begin n_bad++; $display("FAIL misalign_lh_err: got lat %0d err %b want 1/1", lat, e); end
`endif
    do_req(1'b1, 2'b00, 1'b0, Base + 32'h6, 32'h80, rd, e, lat);
    do_req(1'b1, 2'b00, 1'b0, Base + 32'h7, 32'hF0, rd, e, lat);
    do_req(1'b0, 2'b01, 1'b0, Base + 32'h6, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hFFFF_F080 || lat !== 2) begin n_bad++; $display("FAIL lh_aligned: got %h lat %0d want fffff080 lat 2", rd, lat); end
    do_req(1'b0, 2'b01, 1'b1, Base + 32'h6, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000_F080) begin n_bad++; $display("FAIL lhu_aligned: got %h want 0000f080", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat; int a0;
    logic [31:0] addrs [0:2];
    logic [1:0]  sizes [0:2];
    addrs[0] = Base - 32'd4;          sizes[0] = 2'b10;
    addrs[1] = Base + Depth - 32'd2;  sizes[1] = 2'b10;
    addrs[2] = Base + 32'h8;          sizes[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      a0 = act_total;
      do_req(1'b0, sizes[k], 1'b0, addrs[k], 32'h0, rd, e, lat);
      n_vec++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || act_total != a0) begin
        n_bad++;
        $display("FAIL err_case%0d: got lat %0d err %b rd %h memcyc %0d want 1/1/0/0", k, lat, e, rd, act_total - a0);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, Base + Depth - 32'd4, 32'h0, rd, e, lat);
    n_vec++; if (lat !== 2 || e !== 1'b0) begin n_bad++; $display("FAIL last_word_ok: got lat %0d err %b want 2/0", lat, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; int w0; int r0; int g;
    do_req(1'b1, 2'b10, 1'b0, Base + 32'h20, 32'h0, rd, e, lat);
    do_req(1'b1, 2'b10, 1'b0, Base + 32'h24, 32'h0, rd, e, lat);
    w0 = wr_total;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
`ifdef LSU_MISALIGN_EN
    bus.req_addr = Base + 32'h21;
`else
    bus.req_addr = Base + 32'h20;
`endif
    bus.req_wdata = 32'hAABB_CCDD;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
    @(posedge clk);
    #1;
    n_vec++; if (bus.mem_addr !== 32'h22 || bus.mem_read_write !== 1'b1) begin n_bad++; $display("FAIL mid_byte1_drive: got addr %h rw %b want 22/1", bus.mem_addr, bus.mem_read_write); end
`else
    n_vec++; if (bus.mem_addr !== 32'h20 || bus.mem_read_write !== 1'b1) begin n_bad++; $display("FAIL mid_access_drive: got addr %h rw %b want 20/1", bus.mem_addr, bus.mem_read_write); end
`endif
    r0 = resp_total;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (mem_quiet !== 1'b1 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after_reset: got quiet %b resp %b want 1/0", mem_quiet, bus.resp_valid); end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_in_reset: got %b want 0", bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_release: got %b want 1", bus.req_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (resp_total != r0) begin n_bad++; $display("FAIL mid_no_resp: got %0d pulses want 0", resp_total - r0); end
`ifdef LSU_MISALIGN_EN
    n_vec++; if (wr_total - w0 !== 1) begin n_bad++; $display("FAIL mid_writes: got %0d want 1", wr_total - w0); end
    do_req(1'b0, 2'b10, 1'b0, Base + 32'h20, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000_DD00) begin n_bad++; $display("FAIL mid_mem_word: got %h want 0000dd00", rd); end
`else
    n_vec++; if (wr_total - w0 !== 0) begin n_bad++; $display("FAIL mid_writes: got %0d want 0", wr_total - w0); end
    do_req(1'b0, 2'b10, 1'b0, Base + 32'h20, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_mem_word: got %h want 0", rd); end
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_aligned_word();
    test_byte();
    test_misaligned();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
